// File: rtl/time_ctrl_if.sv
// Write-port and time-display bundle for time_ctrl.
// master: button front end / display path side; slave: the controller.
interface time_ctrl_if;
    logic       i_wr;
    logic [1:0] i_sel;
    logic [7:0] i_val;
    logic       o_ready;
    logic       o_wr_ack;
    logic       o_wr_err;
    logic [7:0] o_hours;
    logic [7:0] o_min;
    logic [7:0] o_sec;
    logic       o_pm;

    modport master (
        output i_wr, i_sel, i_val,
        input  o_ready, o_wr_ack, o_wr_err, o_hours, o_min, o_sec, o_pm
    );

    modport slave (
        input  i_wr, i_sel, i_val,
        output o_ready, o_wr_ack, o_wr_err, o_hours, o_min, o_sec, o_pm
    );
endinterface

// File: rtl/time_ctrl.sv
// Time-of-day controller: owns the BCD hh:mm:ss registers and arbitrates between
// the 1 s advance tick (queued in a saturating counter) and validated field writes.
// Define TIME_CTRL_12H_EN for a 12 h clock with live PM flag; default is 24 h.
module time_ctrl #(
    parameter int unsigned TICK_Q_MAX = 3
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_sec_tick,
    input  logic         i_clr,
    output logic         o_tick_lost,
    time_ctrl_if.slave   bus_io
);

    typedef enum logic [1:0] {StIdle, StCheck, StCommit, StTick} state_e;

`ifdef TIME_CTRL_12H_EN
    localparam logic [7:0] HoursRst = 8'h12;
`else
    localparam logic [7:0] HoursRst = 8'h00;
`endif

    state_e     state_q, state_d;
    logic [1:0] pending_q, pending_d;
    logic       lost_q, lost_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] val_q, val_d;
    logic [7:0] hours_q, hours_d;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
`ifdef TIME_CTRL_12H_EN
    logic       pm_q, pm_d;
`endif

    logic ready;
    logic wr_valid;
    logic tick_in;
    logic q_full;
    logic q_inc;
    logic q_dec;

    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'h0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Queued ticks take priority over new writes.
    assign ready = (state_q == StIdle) && (pending_q == 2'd0) && !i_clr;

    // Validate the buffered write.
    always_comb begin
        wr_valid = 1'b0;
        case (sel_q)
            2'd0, 2'd1: wr_valid = bcd_ok(val_q) && (val_q <= 8'h59);
`ifdef TIME_CTRL_12H_EN
            // Bit 7 is the PM flag, not part of the BCD hour.
            2'd2: wr_valid = (val_q[6:5] == 2'b00) && bcd_ok({1'b0, val_q[6:0]}) &&
                             (val_q[6:0] >= 7'h01) && (val_q[6:0] <= 7'h12);
`else
            2'd2: wr_valid = bcd_ok(val_q) && (val_q <= 8'h23);
`endif
            default: wr_valid = 1'b0;
        endcase
    end

    // FSM next state, write buffer capture and response pulses.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        val_d   = val_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        if (i_clr) begin
            // In-flight write is discarded silently.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pending_q != 2'd0) begin
                        state_d = StTick;
                    end else if (bus_io.i_wr && ready) begin
                        sel_d   = bus_io.i_sel;
                        val_d   = bus_io.i_val;
                        state_d = StCheck;
                    end
                end
                StCheck: begin
                    if (wr_valid) begin
                        state_d = StCommit;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
                StCommit: begin
                    ack_d   = 1'b1;
                    state_d = StIdle;
                end
                StTick: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Pending-tick counter; a tick at saturation is lost rather than counted.
    always_comb begin
        tick_in   = i_sec_tick && !i_clr;
        q_full    = (pending_q == 2'(TICK_Q_MAX));
        q_inc     = tick_in && !q_full;
        q_dec     = (state_q == StTick);
        pending_d = pending_q;
        lost_d    = lost_q;
        if (i_clr) begin
            pending_d = 2'd0;
        end else begin
            if (q_inc && !q_dec) begin
                pending_d = pending_q + 2'd1;
            end else if (q_dec && !q_inc) begin
                pending_d = pending_q - 2'd1;
            end
            if (tick_in && q_full) begin
                lost_d = 1'b1;
            end
        end
    end

    // Time registers: clear, 1 s advance with BCD carry, or single-field commit.
    always_comb begin
        hours_d = hours_q;
        min_d   = min_q;
        sec_d   = sec_q;
`ifdef TIME_CTRL_12H_EN
        pm_d    = pm_q;
`endif
        if (i_clr) begin
            hours_d = HoursRst;
            min_d   = 8'h00;
            sec_d   = 8'h00;
`ifdef TIME_CTRL_12H_EN
            pm_d    = 1'b0;
`endif
        end else if (state_q == StTick) begin
            if (sec_q == 8'h59) begin
                sec_d = 8'h00;
                if (min_q == 8'h59) begin
                    min_d = 8'h00;
`ifdef TIME_CTRL_12H_EN
                    if (hours_q == 8'h11) begin
                        hours_d = 8'h12;
                        pm_d    = !pm_q;
                    end else if (hours_q == 8'h12) begin
                        hours_d = 8'h01;
                    end else begin
                        hours_d = bcd_inc(hours_q);
                    end
`else
                    hours_d = (hours_q == 8'h23) ? 8'h00 : bcd_inc(hours_q);
`endif
                end else begin
                    min_d = bcd_inc(min_q);
                end
            end else begin
                sec_d = bcd_inc(sec_q);
            end
        end else if (state_q == StCommit) begin
            case (sel_q)
                2'd0: sec_d = val_q;
                2'd1: min_d = val_q;
`ifdef TIME_CTRL_12H_EN
                2'd2: begin
                    hours_d = {1'b0, val_q[6:0]};
                    pm_d    = val_q[7];
                end
`else
                2'd2: hours_d = val_q;
`endif
                default: ;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= StIdle;
            pending_q <= 2'd0;
            lost_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            sel_q     <= 2'd0;
            val_q     <= 8'h00;
            hours_q   <= HoursRst;
            min_q     <= 8'h00;
            sec_q     <= 8'h00;
`ifdef TIME_CTRL_12H_EN
            pm_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            lost_q    <= lost_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            sel_q     <= sel_d;
            val_q     <= val_d;
            hours_q   <= hours_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
`ifdef TIME_CTRL_12H_EN
            pm_q      <= pm_d;
`endif
        end
    end

    assign bus_io.o_ready  = ready;
    assign bus_io.o_wr_ack = ack_q;
    assign bus_io.o_wr_err = err_q;
    assign bus_io.o_hours  = hours_q;
    assign bus_io.o_min    = min_q;
    assign bus_io.o_sec    = sec_q;
`ifdef TIME_CTRL_12H_EN
    assign bus_io.o_pm     = pm_q;
`else
    assign bus_io.o_pm     = 1'b0;
`endif
    assign o_tick_lost     = lost_q;

endmodule

// File: tb/tb_time_ctrl.sv
// Scoreboard bench for time_ctrl: each write pushes its expected ack/err response,
// a negedge monitor pops and checks whenever the DUT pulses o_wr_ack or o_wr_err.
module tb_time_ctrl;

`ifdef TIME_CTRL_12H_EN
    localparam logic [7:0] RH = 8'h12;
`else
    localparam logic [7:0] RH = 8'h00;
`endif

    logic clk = 1'b0;
    logic rst;
    logic tick;
    logic clr;
    logic lost;

    time_ctrl_if bus ();

    time_ctrl #(.TICK_Q_MAX(3)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_sec_tick  (tick),
        .i_clr       (clr),
        .o_tick_lost (lost),
        .bus_io      (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         ack;
        int         due;
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic       pm;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_time(input string name, input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s, input logic pm);
        check({name, "_time"}, {bus.o_hours, bus.o_min, bus.o_sec, 7'd0, bus.o_pm},
              {h, m, s, 7'd0, pm});
    endtask

    // Monitor: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (bus.o_wr_ack || bus.o_wr_err)) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: ack=%0b err=%0b with nothing expected (cycle %0d)",
                         bus.o_wr_ack, bus.o_wr_err, cyc);
            end else begin
                mon_e = sbq.pop_front();
                check("resp_kind", {30'd0, bus.o_wr_ack, bus.o_wr_err},
                      mon_e.ack ? 32'd2 : 32'd1);
                check("resp_cycle", cyc, mon_e.due);
                check_time("resp", mon_e.h, mon_e.m, mon_e.s, mon_e.pm);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the DUT can accept a write; leaves us at posedge+1.
    task automatic wait_ready(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (bus.o_ready) ok = 1'b1;
            else step();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: o_ready got 0 expected 1 within 60 cycles", tag);
        end
    endtask

    // One write accepted in cycle N; optional ticks in cycles N..N+nticks-1;
    // optional clear (with a same-cycle tick) in cycle N+1.
    task automatic do_write(input string tag, input logic [1:0] sel, input logic [7:0] val,
                            input bit exp_ack, input int nticks, input bit clr_chk,
                            input logic [7:0] eh, input logic [7:0] em,
                            input logic [7:0] es, input logic epm);
        int   n;
        exp_t e;
        wait_ready(tag);
        n = cyc;
        if (!clr_chk) begin
            e.ack = exp_ack;
            e.due = n + (exp_ack ? 3 : 2);
            e.h   = eh;
            e.m   = em;
            e.s   = es;
            e.pm  = epm;
            sbq.push_back(e);
        end
        for (int c = 0; c < 6; c++) begin
            bus.i_wr  = (c == 0);
            bus.i_sel = sel;
            bus.i_val = val;
            tick      = (c < nticks) || (clr_chk && c == 1);
            clr       = clr_chk && (c == 1);
            @(negedge clk);
            if (c == 1) check({tag, "_ready_n1"}, {31'd0, bus.o_ready}, 32'd0);
            if (c == 2) begin
                if (clr_chk) begin
                    check({tag, "_ready_after_clr"}, {31'd0, bus.o_ready}, 32'd1);
                    check_time({tag, "_cleared"}, RH, 8'h00, 8'h00, 1'b0);
                end else if (exp_ack) begin
                    check({tag, "_ready_n2"}, {31'd0, bus.o_ready}, 32'd0);
                end else if (nticks == 0) begin
                    check({tag, "_ready_n2"}, {31'd0, bus.o_ready}, 32'd1);
                end
            end
            if (c == 3 && exp_ack && !clr_chk)
                check({tag, "_ready_n3"}, {31'd0, bus.o_ready}, (nticks == 0) ? 32'd1 : 32'd0);
            step();
        end
        bus.i_wr = 1'b0;
        tick     = 1'b0;
        clr      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        tick      = 1'b0;
        clr       = 1'b0;
        bus.i_wr  = 1'b0;
        bus.i_sel = 2'd0;
        bus.i_val = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state in the first cycle after reset.
        @(negedge clk);
        check("rst_ready", {31'd0, bus.o_ready}, 32'd1);
        check("rst_resp", {30'd0, bus.o_wr_ack, bus.o_wr_err}, 32'd0);
        check("rst_lost", {31'd0, lost}, 32'd0);
        check_time("rst", RH, 8'h00, 8'h00, 1'b0);
        step();

        // Valid minutes write.
        do_write("wr_min", 2'd1, 8'h37, 1'b1, 0, 1'b0, RH, 8'h37, 8'h00, 1'b0);

        // Rejected writes leave time unchanged.
        do_write("bad_nib", 2'd0, 8'h5A, 1'b0, 0, 1'b0, RH, 8'h37, 8'h00, 1'b0);
        do_write("bad_sel", 2'd3, 8'h00, 1'b0, 0, 1'b0, RH, 8'h37, 8'h00, 1'b0);
`ifdef TIME_CTRL_12H_EN
        do_write("bad_hr", 2'd2, 8'h13, 1'b0, 0, 1'b0, RH, 8'h37, 8'h00, 1'b0);
        // Preload 11:59:58 PM.
        do_write("ld_hr", 2'd2, 8'h91, 1'b1, 0, 1'b0, 8'h11, 8'h37, 8'h00, 1'b1);
        do_write("ld_min", 2'd1, 8'h59, 1'b1, 0, 1'b0, 8'h11, 8'h59, 8'h00, 1'b1);
        do_write("ld_sec", 2'd0, 8'h58, 1'b1, 0, 1'b0, 8'h11, 8'h59, 8'h58, 1'b1);
`else
        do_write("bad_hr", 2'd2, 8'h24, 1'b0, 0, 1'b0, RH, 8'h37, 8'h00, 1'b0);
        // Preload 23:59:58.
        do_write("ld_hr", 2'd2, 8'h23, 1'b1, 0, 1'b0, 8'h23, 8'h37, 8'h00, 1'b0);
        do_write("ld_min", 2'd1, 8'h59, 1'b1, 0, 1'b0, 8'h23, 8'h59, 8'h00, 1'b0);
        do_write("ld_sec", 2'd0, 8'h58, 1'b1, 0, 1'b0, 8'h23, 8'h59, 8'h58, 1'b0);
`endif

        // Tick in cycle T: time unchanged at T+2, advanced at T+3.
        wait_ready("tick1");
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        @(negedge clk);
        check("tick_lat_t2", {24'd0, bus.o_sec}, 32'h58);
        step();
        @(negedge clk);
        check("tick_lat_t3", {24'd0, bus.o_sec}, 32'h59);
        step();

        // Second tick wraps the whole day (or PM -> AM at midnight).
        tick = 1'b1;
        step();
        tick = 1'b0;
        wait_ready("tick2");
        @(negedge clk);
        check_time("wrap", RH, 8'h00, 8'h00, 1'b0);
        step();

        // Tick together with an accepted write: write first, then +1 s with carry.
        do_write("wr_tick", 2'd0, 8'h59, 1'b1, 1, 1'b0, RH, 8'h00, 8'h59, 1'b0);
        wait_ready("wr_tick");
        @(negedge clk);
        check_time("wr_tick_after", RH, 8'h01, 8'h00, 1'b0);
        check("lost_before", {31'd0, lost}, 32'd0);
        step();

        // Five ticks during a write: three queued, the rest lost.
        do_write("sat", 2'd1, 8'h10, 1'b1, 5, 1'b0, RH, 8'h10, 8'h00, 1'b0);
        wait_ready("sat");
        @(negedge clk);
        check_time("sat_after", RH, 8'h10, 8'h03, 1'b0);
        check("lost_set", {31'd0, lost}, 32'd1);
        step();

        // Clear during CHECK: write discarded, same-cycle tick dropped.
        do_write("clr", 2'd0, 8'h30, 1'b1, 0, 1'b1, RH, 8'h00, 8'h00, 1'b0);
        repeat (4) step();
        @(negedge clk);
        check_time("clr_settled", RH, 8'h00, 8'h00, 1'b0);
        check("lost_sticky", {31'd0, lost}, 32'd1);
        check("clr_ready", {31'd0, bus.o_ready}, 32'd1);
        step();

        repeat (3) step();
        check("sb_empty", sbq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
